// File: rtl/c_tile_pkg.sv
// Shared types for the result-tile store: controller state, index-width helper, write-merge modes.
// No logic of its own: types and pure functions only.
// No flow control here; the store and drain sequencer apply it.
package c_tile_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // How two same-cycle writes combine into one entry.
    typedef enum logic [1:0] {
        MRG_NONE    = 2'd0,   // different addresses (or at most one port live)
        MRG_ACC_ACC = 2'd1,   // mem + din1 + din2
        MRG_OVR_ACC = 2'd2,   // din1 + din2
        MRG_P2_OVR  = 2'd3    // din2 wins
    } merge_e;

    // Index width for a DIM x DIM tile, never narrower than one bit.
    function automatic int calc_aw(input int dim);
        int depth;
        depth = dim * dim;
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Same-address collision resolution between the two write ports.
    function automatic merge_e merge_mode(input logic same, input logic acc1, input logic acc2);
        if (!same)     return MRG_NONE;
        else if (!acc2) return MRG_P2_OVR;
        else if (acc1)  return MRG_ACC_ACC;
        else            return MRG_OVR_ACC;
    endfunction

endpackage

// File: rtl/c_tile_drain.sv
// Drain sequencer: FILL/DRAIN state, index counter and registered valid/ready output stage.
// Latency: rd_start at edge t gives index 0 valid in cycle t+1, then one entry per accepted beat.
// Backpressure: out_data/out_idx/out_last hold while out_valid && !out_ready; clear aborts.
module c_tile_drain
    import c_tile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   tile_full,
    input  logic                   rd_start,
    input  logic [WIDTH*DEPTH-1:0] tile,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [AW-1:0]          out_idx,
    output logic                   out_last,
    output logic                   draining,
    output logic                   done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d, nxt_idx;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    // Next-state: start on a full tile, advance on each handshake, return to FILL after the last beat.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        done    = 1'b0;
        nxt_idx = idx_q + 1'b1;
        if (clear) begin
            state_d = FILL;
            idx_d   = '0;
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (rd_start && tile_full) begin
                        state_d = DRAIN;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        data_d  = tile[0 +: WIDTH];
                        last_d  = (LAST_IDX == '0);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (last_q) begin
                            state_d = FILL;
                            idx_d   = '0;
                            valid_d = 1'b0;
                            data_d  = '0;
                            last_d  = 1'b0;
                            done    = 1'b1;
                        end else begin
                            idx_d  = nxt_idx;
                            data_d = tile[int'(nxt_idx) * WIDTH +: WIDTH];
                            last_d = (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign draining  = (state_q == DRAIN);

endmodule

// File: rtl/c_tile_store.sv
// Result-tile store: DIM x DIM register file, two overwrite/accumulate write ports, tile-complete flag, drain.
// Latency: writes visible on c_all the cycle after the edge; drain index 0 one cycle after rd_start.
// Backpressure: drain holds on !out_ready; writes during drain or out of range are dropped with wr_drop.
module c_tile_store
    import c_tile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIM   = 2,
    parameter int AW    = calc_aw(DIM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     we1,
    input  logic                     acc1,
    input  logic [AW-1:0]            addr1,
    input  logic [WIDTH-1:0]         din1,
    input  logic                     we2,
    input  logic                     acc2,
    input  logic [AW-1:0]            addr2,
    input  logic [WIDTH-1:0]         din2,
    output logic                     tile_full,
    output logic                     wr_drop,
    input  logic                     rd_start,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [AW-1:0]            out_idx,
    output logic                     out_last,
    output logic [WIDTH*DIM*DIM-1:0] c_all
);

    localparam int            DEPTH   = DIM * DIM;
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] written_q, written_d;
    logic             wr_drop_q, wr_drop_d;
    logic             draining, drain_done;
    logic             v1, v2, same;
    merge_e           mode;

    // Write-combine: range check, same-address merge, flag update, drop reporting.
    always_comb begin
        v1        = we1 && ({1'b0, addr1} < DEPTH_W);
        v2        = we2 && ({1'b0, addr2} < DEPTH_W);
        same      = v1 && v2 && (addr1 == addr2);
        mode      = merge_mode(same, acc1, acc2);
        mem_d     = mem_q;
        written_d = written_q;
        wr_drop_d = 1'b0;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            written_d = '0;
        end else if (draining) begin
            // Tile is frozen while streaming; data survives the drain, flags do not.
            wr_drop_d = we1 || we2;
            if (drain_done) written_d = '0;
        end else begin
            wr_drop_d = (we1 && !v1) || (we2 && !v2);
            case (mode)
                MRG_ACC_ACC: mem_d[addr2] = mem_q[addr2] + din1 + din2;
                MRG_OVR_ACC: mem_d[addr2] = din1 + din2;
                MRG_P2_OVR:  mem_d[addr2] = din2;
                default: begin
                    if (v1) mem_d[addr1] = acc1 ? (mem_q[addr1] + din1) : din1;
                    if (v2) mem_d[addr2] = acc2 ? (mem_q[addr2] + din2) : din2;
                end
            endcase
            if (v1) written_d[addr1] = 1'b1;
            if (v2) written_d[addr2] = 1'b1;
        end
    end

    // Register file, written flags and drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            written_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            written_q <= written_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_call
        assign c_all[g*WIDTH +: WIDTH] = mem_q[g];
    end

    assign tile_full = &written_q;
    assign wr_drop   = wr_drop_q;

    c_tile_drain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_drain (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .tile_full (tile_full),
        .rd_start  (rd_start),
        .tile      (c_all),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .draining  (draining),
        .done      (drain_done)
    );

endmodule

// File: tb/tb_c_tile_store.sv
// Bench for c_tile_store: DIM=2/WIDTH=8 instance for merge, wrap and drain control,
// DIM=4/WIDTH=32 instance for a full two-port accumulate and 16-beat drain.
// Drain beats are checked by scoreboard monitors; other state by direct checks.
module tb_c_tile_store;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    beat_t qa[$];
    beat_t qb[$];

    // Instance A: WIDTH=8, DIM=2
    logic       a_clear, a_we1, a_acc1, a_we2, a_acc2, a_rd_start, a_out_ready;
    logic [1:0] a_addr1, a_addr2;
    logic [7:0] a_din1, a_din2;
    logic       a_tile_full, a_wr_drop, a_out_valid, a_out_last;
    logic [7:0] a_out_data;
    logic [1:0] a_out_idx;
    logic [31:0] a_c_all;

    // Instance B: WIDTH=32, DIM=4
    logic        b_clear, b_we1, b_acc1, b_we2, b_acc2, b_rd_start, b_out_ready;
    logic [3:0]  b_addr1, b_addr2;
    logic [31:0] b_din1, b_din2;
    logic        b_tile_full, b_wr_drop, b_out_valid, b_out_last;
    logic [31:0] b_out_data;
    logic [3:0]  b_out_idx;
    logic [511:0] b_c_all;

    c_tile_store #(.WIDTH(8), .DIM(2)) u_a (
        .clk(clk), .rst(rst), .clear(a_clear),
        .we1(a_we1), .acc1(a_acc1), .addr1(a_addr1), .din1(a_din1),
        .we2(a_we2), .acc2(a_acc2), .addr2(a_addr2), .din2(a_din2),
        .tile_full(a_tile_full), .wr_drop(a_wr_drop), .rd_start(a_rd_start),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_idx(a_out_idx), .out_last(a_out_last), .c_all(a_c_all)
    );

    c_tile_store #(.WIDTH(32), .DIM(4)) u_b (
        .clk(clk), .rst(rst), .clear(b_clear),
        .we1(b_we1), .acc1(b_acc1), .addr1(b_addr1), .din1(b_din1),
        .we2(b_we2), .acc2(b_acc2), .addr2(b_addr2), .din2(b_din2),
        .tile_full(b_tile_full), .wr_drop(b_wr_drop), .rd_start(b_rd_start),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .out_last(b_out_last), .c_all(b_c_all)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every valid cycle against the queue head; pop only on handshake.
    task automatic mon_a();
        forever begin
            @(negedge clk);
            if (a_out_valid) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_beat unexpected idx=%0d data=%0h", a_out_idx, a_out_data);
                end else if (int'(a_out_idx) != qa[0].idx || a_out_data !== qa[0].data[7:0] ||
                             a_out_last !== qa[0].last) begin
                    errors++;
                    $display("FAIL a_beat actual idx=%0d data=%0h last=%0b required idx=%0d data=%0h last=%0b",
                             a_out_idx, a_out_data, a_out_last, qa[0].idx, qa[0].data[7:0], qa[0].last);
                end
                if (a_out_ready && qa.size() != 0) void'(qa.pop_front());
            end
        end
    endtask

    task automatic mon_b();
        forever begin
            @(negedge clk);
            if (b_out_valid) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_beat unexpected idx=%0d data=%0h", b_out_idx, b_out_data);
                end else if (int'(b_out_idx) != qb[0].idx || b_out_data !== qb[0].data ||
                             b_out_last !== qb[0].last) begin
                    errors++;
                    $display("FAIL b_beat actual idx=%0d data=%0h last=%0b required idx=%0d data=%0h last=%0b",
                             b_out_idx, b_out_data, b_out_last, qb[0].idx, qb[0].data, qb[0].last);
                end
                if (b_out_ready && qb.size() != 0) void'(qb.pop_front());
            end
        end
    endtask

    task automatic a_wr(input logic w1, input logic c1, input logic [1:0] ad1, input logic [7:0] d1,
                        input logic w2, input logic c2, input logic [1:0] ad2, input logic [7:0] d2);
        a_we1 = w1; a_acc1 = c1; a_addr1 = ad1; a_din1 = d1;
        a_we2 = w2; a_acc2 = c2; a_addr2 = ad2; a_din2 = d2;
        tick();
        a_we1 = 1'b0; a_we2 = 1'b0;
    endtask

    task automatic b_wr(input logic [3:0] ad1, input logic [31:0] d1,
                        input logic [3:0] ad2, input logic [31:0] d2);
        b_we1 = 1'b1; b_acc1 = 1'b1; b_addr1 = ad1; b_din1 = d1;
        b_we2 = 1'b1; b_acc2 = 1'b1; b_addr2 = ad2; b_din2 = d2;
        tick();
        b_we1 = 1'b0; b_we2 = 1'b0;
    endtask

    task automatic push_a(input int idx, input logic [7:0] data, input logic last);
        beat_t b;
        b.idx = idx; b.data = {24'd0, data}; b.last = last;
        qa.push_back(b);
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_tile_full"}, a_tile_full, 0);
        chk({tag, "_wr_drop"},   a_wr_drop,   0);
        chk({tag, "_out_valid"}, a_out_valid, 0);
        chk({tag, "_out_data"},  a_out_data,  0);
        chk({tag, "_out_idx"},   a_out_idx,   0);
        chk({tag, "_out_last"},  a_out_last,  0);
        chk({tag, "_c_all"},     a_c_all,     0);
    endtask

    initial begin
        logic [5:0] rdy_pat;
        rdy_pat = 6'b111001;   // bit j = out_ready in drain cycle j: 1,0,0,1,1,1
        rst = 1'b0;
        a_clear = 0; a_we1 = 0; a_acc1 = 0; a_addr1 = 0; a_din1 = 0;
        a_we2 = 0; a_acc2 = 0; a_addr2 = 0; a_din2 = 0; a_rd_start = 0; a_out_ready = 0;
        b_clear = 0; b_we1 = 0; b_acc1 = 0; b_addr1 = 0; b_din1 = 0;
        b_we2 = 0; b_acc2 = 0; b_addr2 = 0; b_din2 = 0; b_rd_start = 0; b_out_ready = 0;
        fork
            mon_a();
            mon_b();
        join_none
        #1 rst = 1'b1;
        #2 chk_a_reset("rst");
        chk("rst_b_c_all", {63'd0, b_c_all == '0}, 1);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // Fill 1,2,3,4 over two cycles
        a_wr(1, 0, 2'd0, 8'd1, 1, 0, 2'd1, 8'd2);
        chk("fill_half_full", a_tile_full, 0);
        a_wr(1, 0, 2'd2, 8'd3, 1, 0, 2'd3, 8'd4);
        chk("fill_full", a_tile_full, 1);
        chk("fill_c_all", a_c_all, 32'h04030201);
        chk("fill_no_drop", a_wr_drop, 0);

        // Drain with ready pattern 1,0,0,1,1,1
        push_a(0, 8'd1, 0); push_a(1, 8'd2, 0); push_a(2, 8'd3, 0); push_a(3, 8'd4, 1);
        a_rd_start = 1'b1;
        tick();
        a_rd_start = 1'b0;
        chk("drain_start_valid", a_out_valid, 1);
        for (int j = 0; j < 6; j++) begin
            a_out_ready = rdy_pat[j];
            tick();
        end
        a_out_ready = 1'b0;
        chk("drain_end_valid", a_out_valid, 0);
        chk("drain_end_full", a_tile_full, 0);
        chk("drain_data_kept", a_c_all, 32'h04030201);
        chk("drain_queue_empty", qa.size(), 0);

        // Same-address merges at entry 1
        a_wr(1, 0, 2'd1, 8'd10, 0, 0, 2'd0, 8'd0);
        a_wr(1, 1, 2'd1, 8'd5, 1, 1, 2'd1, 8'd7);
        chk("merge_acc_acc", a_c_all[15:8], 8'd22);
        a_wr(1, 0, 2'd1, 8'd10, 0, 0, 2'd0, 8'd0);
        a_wr(1, 0, 2'd1, 8'd5, 1, 1, 2'd1, 8'd7);
        chk("merge_ovr_acc", a_c_all[15:8], 8'd12);
        a_wr(1, 1, 2'd1, 8'd5, 1, 0, 2'd1, 8'd7);
        chk("merge_p2_wins", a_c_all[15:8], 8'd7);

        // Accumulate wrap on entry 0
        a_wr(1, 0, 2'd0, 8'hF0, 0, 0, 2'd0, 8'd0);
        a_wr(1, 1, 2'd0, 8'h20, 0, 0, 2'd0, 8'd0);
        chk("wrap_value", a_c_all[7:0], 8'h10);
        chk("wrap_no_drop", a_wr_drop, 0);

        // rd_start with three of four entries written is ignored
        a_wr(0, 0, 2'd0, 8'd0, 1, 0, 2'd2, 8'h33);
        chk("partial_full", a_tile_full, 0);
        a_rd_start = 1'b1;
        tick();
        a_rd_start = 1'b0;
        chk("partial_rd_ignored", a_out_valid, 0);
        tick();
        chk("partial_rd_still_idle", a_out_valid, 0);

        // Complete the tile, drain, write while stalled, then clear at idx 2
        a_wr(1, 0, 2'd3, 8'h44, 0, 0, 2'd0, 8'd0);
        chk("refill_full", a_tile_full, 1);
        chk("refill_c_all", a_c_all, 32'h44330710);
        push_a(0, 8'h10, 0); push_a(1, 8'h07, 0); push_a(2, 8'h33, 0);
        a_rd_start = 1'b1;
        tick();
        a_rd_start = 1'b0;
        a_wr(1, 1, 2'd0, 8'h55, 1, 0, 2'd3, 8'h66);
        chk("drain_wr_drop", a_wr_drop, 1);
        chk("drain_wr_c_all", a_c_all, 32'h44330710);
        tick();
        chk("drain_wr_drop_pulse", a_wr_drop, 0);
        a_out_ready = 1'b1;
        tick();
        tick();
        a_out_ready = 1'b0;
        chk("clear_at_idx", a_out_idx, 2'd2);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        chk("clear_valid", a_out_valid, 0);
        chk("clear_c_all", a_c_all, 0);
        chk("clear_full", a_tile_full, 0);
        qa = {};   // aborted beats are never presented

        // Async reset mid-drain
        a_wr(1, 0, 2'd0, 8'h11, 1, 0, 2'd1, 8'h22);
        a_wr(1, 0, 2'd2, 8'h33, 1, 0, 2'd3, 8'h44);
        push_a(0, 8'h11, 0);
        a_rd_start = 1'b1;
        tick();
        a_rd_start = 1'b0;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("arst_pre_idx", a_out_idx, 2'd1);
        #1 rst = 1'b1;
        #1 chk_a_reset("arst");
        @(posedge clk); #1 rst = 1'b0;
        chk("arst_queue_empty", qa.size(), 0);

        // DIM=4: two-pass two-port accumulate plus one same-address accumulate
        for (int k = 0; k < 8; k++)
            b_wr(4'(2*k), 32'(3*(2*k) + 1), 4'(2*k+1), 32'(3*(2*k+1) + 1));
        chk("b_full_after_pass1", b_tile_full, 1);
        for (int k = 0; k < 8; k++)
            b_wr(4'(2*k+1), 32'(1000*(2*k+1) + 7), 4'(2*k), 32'(1000*(2*k) + 7));
        b_wr(4'd5, 32'd1, 4'd5, 32'd2);
        chk("b_entry5", b_c_all[5*32 +: 32], 32'd5026);
        for (int i = 0; i < 16; i++) begin
            beat_t b;
            b.idx  = i;
            b.data = 32'(1003*i + 8 + ((i == 5) ? 3 : 0));
            b.last = (i == 15);
            qb.push_back(b);
        end
        b_out_ready = 1'b1;
        b_rd_start = 1'b1;
        tick();
        b_rd_start = 1'b0;
        repeat (16) tick();
        b_out_ready = 1'b0;
        chk("b_drain_done_valid", b_out_valid, 0);
        chk("b_drain_done_full", b_tile_full, 0);
        chk("b_queue_empty", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c_tile_store.md
# c_tile_store

Parametrised result-tile store for the Strassen datapath: holds one DIM×DIM output tile in a flat register file. Two write ports support overwrite or accumulate (partial-product summation) with defined same-address merging. Per-entry written flags raise a tile-complete flag. A valid/ready sequencer drains the finished tile in index order, while the full tile stays visible in parallel for the existing combinational consumers.

## Interface
Parameters:
- WIDTH, 32, entry width in bits
- DIM, 2, tile edge; DEPTH = DIM*DIM entries, row-major (index = row*DIM + col)
- AW, $clog2(DIM*DIM) (min 1), index width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- clear  in  1  synchronous: zero tile, drop flags, abort drain
- we1  in  1  port-1 write enable
- acc1  in  1  port-1 mode: 1 = accumulate (mem + d), 0 = overwrite
- addr1  in  AW  port-1 index
- din1  in  WIDTH  port-1 data
- we2, acc2, addr2, din2  in  1/1/AW/WIDTH  port 2, same meaning
- tile_full  out  1  all DEPTH entries written since last clear/drain
- wr_drop  out  1  one-cycle pulse: a write was ignored (in DRAIN or addr ≥ DEPTH)
- rd_start  in  1  request drain; honoured only when tile_full=1 in FILL
- out_valid  out  1  drain data valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  entry being drained
- out_idx  out  AW  index of out_data
- out_last  out  1  out_data is entry DEPTH-1
- c_all  out  WIDTH*DEPTH  whole tile, entry i at bits [i*WIDTH +: WIDTH]

## Operation
- States: FILL (accept writes), DRAIN (stream out, writes dropped).
- Reset: all entries 0, written flags 0, state FILL. Outputs: tile_full 0, wr_drop 0, out_valid 0, out_data 0, out_idx 0, out_last 0, c_all 0.
- Writes in FILL with addr < DEPTH update the entry and set its written flag. Accumulate uses modulo-2^WIDTH add; overflow wraps with no flag.
- Same address, both ports enabled:
  - acc1=1, acc2=1: mem + din1 + din2.
  - acc1=0, acc2=1: din1 + din2.
  - acc2=0: din2 (port-2 overwrite wins).
- Different addresses: both ports update independently.
- tile_full = AND of all written flags.
- FILL→DRAIN: rd_start while tile_full=1. rd_start at other times is ignored.
- DRAIN: emits entries 0..DEPTH-1 in order. Each index is held until out_valid && out_ready. out_last=1 on index DEPTH-1.
- DRAIN→FILL after the final handshake. Written flags clear; data is kept, so accumulation continues on top unless clear is used.
- clear (either state, priority over writes and rd_start): all entries 0, flags 0, out_valid 0, state FILL.
- In DRAIN, writes and accumulates do not modify data; each dropped cycle pulses wr_drop. Out-of-range addr in FILL also pulses wr_drop.

## Timing
- Write at edge t: visible on c_all and in the flags after edge t; tile_full high in cycle t+1 if that write completed the tile.
- Accumulate reads the pre-edge value, so back-to-back accumulates to one entry each take effect, one per cycle.
- rd_start sampled at edge t: out_valid=1, out_idx=0 in cycle t+1.
- With out_ready held 1: one entry per cycle, and out_last is seen in cycle t+DEPTH. State is FILL with tile_full=0 in cycle t+DEPTH+1.
- out_data, out_idx and out_last are registered and remain stable while out_valid && !out_ready.
- Async rst mid-drain: everything returns to reset values immediately. clear mid-drain takes effect at the next edge.

## Structure
- Package c_tile_pkg:
  - state enum {FILL, DRAIN}
  - the AW derivation helper
  - the merge-mode encoding used by the write-combine logic
- Sub-module c_tile_drain: state register, drain index counter and valid/ready output registers. Inputs: tile_full, rd_start, clear, tile bus. Outputs: the out_* signals plus a done pulse used to clear the flags.
- The register file, write-combine logic and written flags stay in the top module.

## Test plan
- DIM=2: overwrite entries 0..3 with 1,2,3,4 via both ports (2 cycles) → tile_full=1 in the next cycle; c_all = {4,3,2,1}.
- Same-address merge at entry 1 (holding 10), din1=5, din2=7:
  - acc1=acc2=1 → 22
  - acc1=0, acc2=1 → 12
  - acc2=0 → 7
- Accumulate wrap, WIDTH=8: entry = 0xF0, accumulate 0x20 → 0x10, no wr_drop.
- Drain with out_ready pattern 1,0,0,1,1,1 → idx 0,1,1,1,2,3 on valid, data stable during stalls. out_last only with idx 3, then tile_full=0 and state FILL.
- Write during DRAIN → wr_drop pulse, c_all unchanged.
- rd_start with 3 of 4 entries written → ignored.
- clear mid-drain at idx 2 → out_valid 0 next cycle, c_all 0.
- Async rst mid-drain → all outputs at reset values.
- DIM=4 full accumulate of 16 entries from two ports → 16 drained beats in index order with correct sums.
